wishbone_arbiter: RTL and testbench

Two-to-one classic Wishbone arbiter between the CPU's instruction bus and data bus and a single shared memory port. Sits directly downstream of the CPU: instruction fetches and loads/stores leave through it to the memory/SoC interconnect. Provides fair alternation on contention, holds a grant for a full `cyc` cycle, and converts a hung slave into a bus error via a watchdog.

---
 rtl/icicle_wb_pkg.sv | 15 +
 rtl/wb_watchdog.sv | 32 +++
 rtl/wishbone_arbiter.sv | 152 +++++++++++++++
 tb/tb_wishbone_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icicle_wb_pkg.sv
// Shared Wishbone definitions for the icicle CPU bus fabric.
// Contents: bus field widths and the arbiter grant encoding.
package icicle_wb_pkg;

  localparam int unsigned WB_ADR_W = 30;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  typedef enum logic [1:0] {
    GRANT_IDLE = 2'd0,
    GRANT_IBUS = 2'd1,
    GRANT_DBUS = 2'd2
  } grant_t;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts consecutive unanswered strobe cycles and flags expiry.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   clear        : zero the count (ack/err seen, or no grant held)
//   busy         : a strobe cycle is outstanding with no ack/err this cycle
//   expired      : count has reached TIMEOUT (never asserted when TIMEOUT=0)
module wb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic busy,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] r_count;

  // Counter holds at TIMEOUT so expiry cannot wrap back to zero.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (busy && !expired) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (r_count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/wishbone_arbiter.sv
// Two-to-one classic Wishbone arbiter: CPU instruction bus and data bus onto
// one shared memory port, alternating on contention, with a hung-slave watchdog.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   ibus_*                : instruction master (read-only, word addressed)
//   dbus_*                : data master (loads/stores with byte lanes)
//   mem_*                 : shared slave port
// Forward and return paths are combinational from the registered grant.
module wishbone_arbiter
  import icicle_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [WB_ADR_W-1:0] ibus_adr,
  input  logic                ibus_cyc,
  input  logic                ibus_stb,
  output logic [WB_DAT_W-1:0] ibus_dat_r,
  output logic                ibus_ack,
  output logic                ibus_err,
  input  logic [WB_ADR_W-1:0] dbus_adr,
  input  logic [WB_DAT_W-1:0] dbus_dat_w,
  input  logic [WB_SEL_W-1:0] dbus_sel,
  input  logic                dbus_we,
  input  logic                dbus_cyc,
  input  logic                dbus_stb,
  output logic [WB_DAT_W-1:0] dbus_dat_r,
  output logic                dbus_ack,
  output logic                dbus_err,
  output logic [WB_ADR_W-1:0] mem_adr,
  output logic [WB_DAT_W-1:0] mem_dat_w,
  output logic [WB_SEL_W-1:0] mem_sel,
  output logic                mem_we,
  output logic                mem_cyc,
  output logic                mem_stb,
  input  logic [WB_DAT_W-1:0] mem_dat_r,
  input  logic                mem_ack,
  input  logic                mem_err
);

  grant_t r_grant;
  grant_t r_last;

  logic w_req_i;
  logic w_req_d;
  logic w_m_cyc;
  logic w_m_stb;
  logic w_busy;
  logic w_clear;
  logic w_expired;
  logic w_timeout;

  assign w_req_i = ibus_cyc & ibus_stb;
  assign w_req_d = dbus_cyc & dbus_stb;

  // Cycle/strobe of whichever master currently owns the port.
  always_comb begin
    w_m_cyc = 1'b0;
    w_m_stb = 1'b0;
    case (r_grant)
      GRANT_IBUS: begin
        w_m_cyc = ibus_cyc;
        w_m_stb = ibus_stb;
      end
      GRANT_DBUS: begin
        w_m_cyc = dbus_cyc;
        w_m_stb = dbus_stb;
      end
      default: ;
    endcase
  end

  // Count resets through every IDLE cycle, so each grant starts from zero.
  assign w_busy  = w_m_cyc & w_m_stb & ~mem_ack & ~mem_err;
  assign w_clear = (r_grant == GRANT_IDLE) | mem_ack | mem_err;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (w_clear),
    .busy    (w_busy),
    .expired (w_expired)
  );

  // A slave answer in the expiry cycle takes priority over the forced error.
  assign w_timeout = w_expired & ~mem_ack & ~mem_err & (r_grant != GRANT_IDLE);

  // Grant FSM: tie goes to the master that was not served last.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_grant <= GRANT_IDLE;
      r_last  <= GRANT_DBUS;
    end else begin
      case (r_grant)
        GRANT_IDLE: begin
          if (w_req_i && (!w_req_d || (r_last != GRANT_IBUS))) begin
            r_grant <= GRANT_IBUS;
            r_last  <= GRANT_IBUS;
          end else if (w_req_d) begin
            r_grant <= GRANT_DBUS;
            r_last  <= GRANT_DBUS;
          end
        end
        GRANT_IBUS, GRANT_DBUS: begin
          if (!w_m_cyc || w_timeout) begin
            r_grant <= GRANT_IDLE;
          end
        end
        default: r_grant <= GRANT_IDLE;
      endcase
    end
  end

  // Forward path; instruction fetches are always full-word reads.
  always_comb begin
    mem_adr   = '0;
    mem_dat_w = '0;
    mem_sel   = '0;
    mem_we    = 1'b0;
    mem_cyc   = 1'b0;
    mem_stb   = 1'b0;
    case (r_grant)
      GRANT_IBUS: begin
        mem_adr = ibus_adr;
        mem_sel = '1;
        mem_cyc = ibus_cyc & ~w_timeout;
        mem_stb = ibus_stb & ~w_timeout;
      end
      GRANT_DBUS: begin
        mem_adr   = dbus_adr;
        mem_dat_w = dbus_dat_w;
        mem_sel   = dbus_sel;
        mem_we    = dbus_we;
        mem_cyc   = dbus_cyc & ~w_timeout;
        mem_stb   = dbus_stb & ~w_timeout;
      end
      default: ;
    endcase
  end

  // Return path: handshakes only to the owner, read data to both.
  assign ibus_ack   = (r_grant == GRANT_IBUS) & mem_ack;
  assign ibus_err   = (r_grant == GRANT_IBUS) & (mem_err | w_timeout);
  assign dbus_ack   = (r_grant == GRANT_DBUS) & mem_ack;
  assign dbus_err   = (r_grant == GRANT_DBUS) & (mem_err | w_timeout);
  assign ibus_dat_r = mem_dat_r;
  assign dbus_dat_r = mem_dat_r;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Self-checking bench for wishbone_arbiter (TIMEOUT=4): directed scenarios
// followed by random traffic, all checked against a cycle-level reference model.
module tb_wishbone_arbiter;

  localparam int TO = 4;

  logic        clock;
  logic        reset;
  logic [29:0] ibus_adr;
  logic        ibus_cyc, ibus_stb;
  logic [31:0] ibus_dat_r;
  logic        ibus_ack, ibus_err;
  logic [29:0] dbus_adr;
  logic [31:0] dbus_dat_w;
  logic [3:0]  dbus_sel;
  logic        dbus_we, dbus_cyc, dbus_stb;
  logic [31:0] dbus_dat_r;
  logic        dbus_ack, dbus_err;
  logic [29:0] mem_adr;
  logic [31:0] mem_dat_w;
  logic [3:0]  mem_sel;
  logic        mem_we, mem_cyc, mem_stb;
  logic [31:0] mem_dat_r;
  logic        mem_ack, mem_err;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: who owns the port (0 none, 1 ibus, 2 dbus), who was
  // served last, and how many unanswered strobe cycles the owner has seen.
  int m_owner = 0;
  int m_last  = 2;
  int m_wait  = 0;

  wishbone_arbiter #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .ibus_adr(ibus_adr), .ibus_cyc(ibus_cyc), .ibus_stb(ibus_stb),
    .ibus_dat_r(ibus_dat_r), .ibus_ack(ibus_ack), .ibus_err(ibus_err),
    .dbus_adr(dbus_adr), .dbus_dat_w(dbus_dat_w), .dbus_sel(dbus_sel),
    .dbus_we(dbus_we), .dbus_cyc(dbus_cyc), .dbus_stb(dbus_stb),
    .dbus_dat_r(dbus_dat_r), .dbus_ack(dbus_ack), .dbus_err(dbus_err),
    .mem_adr(mem_adr), .mem_dat_w(mem_dat_w), .mem_sel(mem_sel),
    .mem_we(mem_we), .mem_cyc(mem_cyc), .mem_stb(mem_stb),
    .mem_dat_r(mem_dat_r), .mem_ack(mem_ack), .mem_err(mem_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Let inputs settle, then compare every output with the model.
  task automatic settle();
    logic [29:0] e_adr;
    logic [31:0] e_dw;
    logic [3:0]  e_sel;
    logic e_we, e_cyc, e_stb, tmo, ia, ie, da, de;
    #1;
    tmo   = (m_owner != 0) && (m_wait == TO) && !mem_ack && !mem_err;
    e_adr = '0; e_dw = '0; e_sel = '0;
    e_we  = 1'b0; e_cyc = 1'b0; e_stb = 1'b0;
    ia = 1'b0; ie = 1'b0; da = 1'b0; de = 1'b0;
    if (m_owner == 1) begin
      e_adr = ibus_adr; e_sel = 4'hF;
      e_cyc = ibus_cyc && !tmo; e_stb = ibus_stb && !tmo;
      ia = mem_ack; ie = mem_err || tmo;
    end else if (m_owner == 2) begin
      e_adr = dbus_adr; e_dw = dbus_dat_w; e_sel = dbus_sel; e_we = dbus_we;
      e_cyc = dbus_cyc && !tmo; e_stb = dbus_stb && !tmo;
      da = mem_ack; de = mem_err || tmo;
    end
    chk("mem_adr",    32'(mem_adr),   32'(e_adr));
    chk("mem_dat_w",  mem_dat_w,      e_dw);
    chk("mem_sel",    32'(mem_sel),   32'(e_sel));
    chk("mem_we",     32'(mem_we),    32'(e_we));
    chk("mem_cyc",    32'(mem_cyc),   32'(e_cyc));
    chk("mem_stb",    32'(mem_stb),   32'(e_stb));
    chk("ibus_ack",   32'(ibus_ack),  32'(ia));
    chk("ibus_err",   32'(ibus_err),  32'(ie));
    chk("dbus_ack",   32'(dbus_ack),  32'(da));
    chk("dbus_err",   32'(dbus_err),  32'(de));
    chk("ibus_dat_r", ibus_dat_r,     mem_dat_r);
    chk("dbus_dat_r", dbus_dat_r,     mem_dat_r);
  endtask

  // Advance the model by one clock from the current inputs, then step the clock.
  task automatic tick();
    logic c, s, tmo, ri, rd;
    if (reset) begin
      m_owner = 0; m_last = 2; m_wait = 0;
    end else if (m_owner == 0) begin
      ri = ibus_cyc && ibus_stb;
      rd = dbus_cyc && dbus_stb;
      if (ri && rd)  m_owner = (m_last == 1) ? 2 : 1;
      else if (ri)   m_owner = 1;
      else if (rd)   m_owner = 2;
      if (m_owner != 0) m_last = m_owner;
      m_wait = 0;
    end else begin
      c   = (m_owner == 1) ? ibus_cyc : dbus_cyc;
      s   = (m_owner == 1) ? ibus_stb : dbus_stb;
      tmo = (m_wait == TO) && !mem_ack && !mem_err;
      if (mem_ack || mem_err) m_wait = 0;
      else if (c && s)        m_wait++;
      if (!c || tmo) m_owner = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic quiet();
    ibus_adr = '0; ibus_cyc = 1'b0; ibus_stb = 1'b0;
    dbus_adr = '0; dbus_dat_w = '0; dbus_sel = '0; dbus_we = 1'b0;
    dbus_cyc = 1'b0; dbus_stb = 1'b0;
    mem_dat_r = '0; mem_ack = 1'b0; mem_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic hang;

  initial begin
    quiet();
    reset = 1'b1;
    @(posedge clock);
    #1;
    step();
    chk("rst_mem_cyc", 32'(mem_cyc), 32'd0);
    chk("rst_ibus_ack", 32'(ibus_ack), 32'd0);
    reset = 1'b0;

    // Instruction fetch at 0x100, two wait states, read data 0xDEADBEEF.
    ibus_adr = 30'h40; ibus_cyc = 1'b1; ibus_stb = 1'b1;
    settle(); chk("t1_c0_cyc", 32'(mem_cyc), 32'd0); tick();
    settle(); chk("t1_c1_cyc", 32'(mem_cyc), 32'd1);
    chk("t1_c1_adr", 32'(mem_adr), 32'h40); tick();
    step();
    mem_ack = 1'b1; mem_dat_r = 32'hDEADBEEF;
    settle(); chk("t1_c3_ack", 32'(ibus_ack), 32'd1);
    chk("t1_c3_dat", ibus_dat_r, 32'hDEADBEEF);
    chk("t1_c3_dack", 32'(dbus_ack), 32'd0); tick();
    quiet(); step(); step();

    // Contention: ibus first after reset, then dbus, then ibus again.
    do_reset();
    ibus_adr = 30'h111; ibus_cyc = 1'b1; ibus_stb = 1'b1;
    dbus_adr = 30'h222; dbus_cyc = 1'b1; dbus_stb = 1'b1;
    step();
    mem_ack = 1'b1;
    settle(); chk("t2_ibus_first", 32'(mem_adr), 32'h111);
    chk("t2_ibus_ack", 32'(ibus_ack), 32'd1); tick();
    mem_ack = 1'b0; ibus_cyc = 1'b0; ibus_stb = 1'b0;
    step();
    ibus_cyc = 1'b1; ibus_stb = 1'b1;
    step();
    mem_ack = 1'b1;
    settle(); chk("t2_dbus_second", 32'(mem_adr), 32'h222);
    chk("t2_dbus_ack", 32'(dbus_ack), 32'd1); tick();
    mem_ack = 1'b0; dbus_cyc = 1'b0; dbus_stb = 1'b0;
    step();
    dbus_cyc = 1'b1; dbus_stb = 1'b1;
    step();
    settle(); chk("t2_ibus_third", 32'(mem_adr), 32'h111); tick();
    quiet(); step(); step();

    // Data store at 0x40, lanes 0..1.
    dbus_adr = 30'h10; dbus_sel = 4'b0011; dbus_dat_w = 32'h1234; dbus_we = 1'b1;
    dbus_cyc = 1'b1; dbus_stb = 1'b1;
    step();
    mem_ack = 1'b1;
    settle(); chk("t3_we", 32'(mem_we), 32'd1);
    chk("t3_sel", 32'(mem_sel), 32'h3);
    chk("t3_dat_w", mem_dat_w, 32'h1234); tick();
    quiet(); step(); step();

    // Hung slave: forced error on the fifth strobe cycle, then one IDLE cycle.
    dbus_adr = 30'h33; dbus_cyc = 1'b1; dbus_stb = 1'b1;
    step();
    for (int i = 0; i < TO; i++) step();
    settle(); chk("t4_err", 32'(dbus_err), 32'd1);
    chk("t4_cyc_low", 32'(mem_cyc), 32'd0); tick();
    settle(); chk("t4_idle", 32'(mem_cyc), 32'd0); tick();
    mem_ack = 1'b1; step();
    quiet(); step(); step();

    // Ack arriving in the expiry cycle beats the watchdog.
    dbus_adr = 30'h44; dbus_cyc = 1'b1; dbus_stb = 1'b1;
    step();
    for (int i = 0; i < TO; i++) step();
    mem_ack = 1'b1;
    settle(); chk("t5_ack", 32'(dbus_ack), 32'd1);
    chk("t5_no_err", 32'(dbus_err), 32'd0); tick();
    quiet(); step(); step();

    // Reset while dbus waits; a late ack must be dropped.
    dbus_adr = 30'h55; dbus_cyc = 1'b1; dbus_stb = 1'b1;
    step(); step();
    reset = 1'b1; step();
    reset = 1'b0; dbus_cyc = 1'b0; dbus_stb = 1'b0; mem_ack = 1'b1;
    settle(); chk("t6_cyc_low", 32'(mem_cyc), 32'd0);
    chk("t6_dack", 32'(dbus_ack), 32'd0);
    chk("t6_iack", 32'(ibus_ack), 32'd0); tick();
    quiet(); step();

    // Random traffic with occasional hung-slave phases and resets.
    hang = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 5) == 0) ibus_cyc = ~ibus_cyc;
      if ($urandom_range(0, 5) == 0) dbus_cyc = ~dbus_cyc;
      ibus_stb   = ibus_cyc & ($urandom_range(0, 3) != 0);
      dbus_stb   = dbus_cyc & ($urandom_range(0, 3) != 0);
      ibus_adr   = 30'($urandom);
      dbus_adr   = 30'($urandom);
      dbus_dat_w = $urandom;
      dbus_sel   = 4'($urandom);
      dbus_we    = 1'($urandom);
      if ($urandom_range(0, 63) == 0) hang = ~hang;
      mem_ack    = !hang && ($urandom_range(0, 2) == 0);
      mem_err    = !hang && ($urandom_range(0, 15) == 0);
      mem_dat_r  = $urandom;
      reset      = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
